layer_compositor: RTL and testbench

//  Parametrised N-layer pixel compositor with splash/run sequencing and horizontal scroll generator.

---
 rtl/layer_compositor.sv | 161 ++++++++++++++++
 tb/tb_layer_compositor.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/layer_compositor.sv
// N-layer pixel compositor with splash/run/pause sequencing and a frame-locked scroll counter.
// Define LAYER_KEY_EN to make pixels equal to KEY_COLOR transparent.
module layer_compositor #(
   parameter int                 LAYERS        = 3,
   parameter int                 COLOR_W       = 12,
   parameter int                 SPLASH_CYCLES = 500_000_000,
   parameter logic [LAYERS-1:0]  SPLASH_MASK   = 3'b001,
   parameter int                 SCROLL_W      = 10,
   parameter int                 SCROLL_MAX    = 639,
   parameter int                 SCROLL_DIV    = 1,
   parameter logic [COLOR_W-1:0] KEY_COLOR     = 12'h000
) (
   input  logic                       clk,
   input  logic                       clr_n,
   input  logic                       video_on,
   input  logic                       f_tick,
   input  logic                       skip,
   input  logic                       pause,
   input  logic [LAYERS-1:0]          layer_on,
   input  logic [LAYERS-1:0]          layer_mask,
   input  logic [LAYERS*COLOR_W-1:0]  rgb_in,
   input  logic [COLOR_W-1:0]         bg_rgb,
   output logic [COLOR_W-1:0]         rgb,
   output logic                       rgb_valid,
   output logic                       hit,
   output logic                       game_begin,
   output logic [1:0]                 state,
   output logic [SCROLL_W-1:0]        scroll_x
);

   localparam int TIMER_W = (SPLASH_CYCLES > 1) ? $clog2(SPLASH_CYCLES) : 1;
   localparam int DIV_W   = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
   localparam logic [TIMER_W-1:0]  TIMER_LAST  = TIMER_W'(SPLASH_CYCLES - 1);
   localparam logic [DIV_W-1:0]    DIV_LAST    = DIV_W'(SCROLL_DIV - 1);
   localparam logic [SCROLL_W-1:0] SCROLL_LAST = SCROLL_W'(SCROLL_MAX);

   typedef enum logic [1:0] {
      ST_SPLASH = 2'b00,
      ST_RUN    = 2'b01,
      ST_PAUSE  = 2'b10,
      ST_BAD    = 2'b11
   } state_t;

   state_t              state_reg, state_next;
   logic [TIMER_W-1:0]  timer_reg, timer_next;
   logic [DIV_W-1:0]    div_reg, div_next;
   logic [SCROLL_W-1:0] scroll_reg, scroll_next;
   logic                game_begin_reg, game_begin_next;
   logic [COLOR_W-1:0]  rgb_reg, rgb_next;
   logic                rgb_valid_reg, hit_reg, hit_next;

   logic [LAYERS-1:0]   eff;
   logic [COLOR_W-1:0]  win_rgb;
   logic                in_splash;
   logic                scroll_en;

   assign in_splash = (state_reg == ST_SPLASH);

   genvar gi;
   generate
      for (gi = 0; gi < LAYERS; gi++) begin : g_eff
         logic key_ok;
`ifdef LAYER_KEY_EN
         assign key_ok = (rgb_in[gi*COLOR_W +: COLOR_W] != KEY_COLOR);
`else
         // Keying disabled: the compare is forced true so colour never affects priority.
         assign key_ok = (rgb_in[gi*COLOR_W +: COLOR_W] != KEY_COLOR) | 1'b1;
`endif
         assign eff[gi] = layer_on[gi] & layer_mask[gi]
                        & ~(in_splash & SPLASH_MASK[gi]) & key_ok;
      end
   endgenerate

   // Ascending scan: the last (highest-index) effective layer overrides lower ones.
   always_comb begin
      win_rgb = bg_rgb;
      for (int i = 0; i < LAYERS; i++) begin
         if (eff[i]) begin
            win_rgb = rgb_in[i*COLOR_W +: COLOR_W];
         end
      end
   end

   always_comb begin
      rgb_next = video_on ? win_rgb : '0;
      hit_next = video_on & (|eff);
   end

   always_comb begin
      state_next = state_reg;
      timer_next = timer_reg;
      case (state_reg)
         ST_SPLASH: begin
            if (skip || (timer_reg == TIMER_LAST)) begin
               state_next = ST_RUN;
               timer_next = '0;
            end else begin
               timer_next = timer_reg + TIMER_W'(1);
            end
         end
         ST_RUN: begin
            if (pause) state_next = ST_PAUSE;
         end
         ST_PAUSE: begin
            if (!pause) state_next = ST_RUN;
         end
         default: begin
            state_next = ST_SPLASH;
            timer_next = '0;
         end
      endcase
   end

   assign game_begin_next = game_begin_reg | (state_next == ST_RUN);

   // Ticks only advance while actually running; the edge leaving SPLASH sees state SPLASH.
   assign scroll_en = (state_reg == ST_RUN) & ~pause & f_tick;

   always_comb begin
      div_next    = div_reg;
      scroll_next = scroll_reg;
      if (scroll_en) begin
         if (div_reg == DIV_LAST) begin
            div_next    = '0;
            scroll_next = (scroll_reg == SCROLL_LAST) ? '0 : scroll_reg + SCROLL_W'(1);
         end else begin
            div_next = div_reg + DIV_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         state_reg      <= ST_SPLASH;
         timer_reg      <= '0;
         div_reg        <= '0;
         scroll_reg     <= '0;
         game_begin_reg <= 1'b0;
         rgb_reg        <= '0;
         rgb_valid_reg  <= 1'b0;
         hit_reg        <= 1'b0;
      end else begin
         state_reg      <= state_next;
         timer_reg      <= timer_next;
         div_reg        <= div_next;
         scroll_reg     <= scroll_next;
         game_begin_reg <= game_begin_next;
         rgb_reg        <= rgb_next;
         rgb_valid_reg  <= video_on;
         hit_reg        <= hit_next;
      end
   end

   assign rgb        = rgb_reg;
   assign rgb_valid  = rgb_valid_reg;
   assign hit        = hit_reg;
   assign game_begin = game_begin_reg;
   assign state      = state_reg;
   assign scroll_x   = scroll_reg;

endmodule

// File: tb/tb_layer_compositor.sv
// Scoreboard bench for layer_compositor: pixel expectations are queued by stimulus and checked by a monitor.
module tb_layer_compositor;

   localparam logic [11:0] CA = 12'h1A1;
   localparam logic [11:0] CB = 12'h2B2;
   localparam logic [11:0] CC = 12'h3C3;
   localparam logic [11:0] BG = 12'h456;

   logic        clk = 1'b0;
   logic        clr_n = 1'b0;
   logic        video_on = 1'b0;
   logic        f_tick = 1'b0;
   logic        skip = 1'b0;
   logic        pause = 1'b0;
   logic [2:0]  layer_on = '0;
   logic [2:0]  layer_mask = '0;
   logic [35:0] rgb_in = '0;
   logic [11:0] bg_rgb = BG;
   logic [11:0] rgb;
   logic        rgb_valid;
   logic        hit;
   logic        game_begin;
   logic [1:0]  state;
   logic [9:0]  scroll_x;

   layer_compositor #(
      .LAYERS(3), .COLOR_W(12), .SPLASH_CYCLES(10), .SPLASH_MASK(3'b001),
      .SCROLL_W(10), .SCROLL_MAX(3), .SCROLL_DIV(2), .KEY_COLOR(12'h000)
   ) dut (
      .clk(clk), .clr_n(clr_n), .video_on(video_on), .f_tick(f_tick),
      .skip(skip), .pause(pause), .layer_on(layer_on), .layer_mask(layer_mask),
      .rgb_in(rgb_in), .bg_rgb(bg_rgb), .rgb(rgb), .rgb_valid(rgb_valid),
      .hit(hit), .game_begin(game_begin), .state(state), .scroll_x(scroll_x)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string       name;
      logic [11:0] rgb;
      logic        valid;
      logic        hit;
   } px_t;

   px_t  exp_q[$];
   px_t  mon_p;
   logic px_issue = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end else begin
         $display("ok   %s: %0h", name, act);
      end
   endtask

   // Called at a negedge; the registered response is checked after the following posedge.
   task automatic pixel(input string name, input logic vid, input logic [2:0] on,
                        input logic [2:0] mask, input logic [11:0] e_rgb, input logic e_hit);
      px_t p;
      video_on   = vid;
      layer_on   = on;
      layer_mask = mask;
      p.name  = name;
      p.rgb   = e_rgb;
      p.valid = vid;
      p.hit   = e_hit;
      exp_q.push_back(p);
      px_issue = 1'b1;
      @(negedge clk);
      px_issue = 1'b0;
   endtask

   task automatic tick();
      f_tick = 1'b1;
      @(negedge clk);
      f_tick = 1'b0;
      @(negedge clk);
   endtask

   task automatic do_reset();
      pixel("pre_reset", 1'b1, 3'b111, 3'b111, CC, 1'b1);
      #2 clr_n = 1'b0;
      #1;
      check("async_reset_rgb", rgb, 0);
      check("async_reset_valid", rgb_valid, 0);
      check("async_reset_state", state, 0);
      check("async_reset_scroll", scroll_x, 0);
      check("async_reset_game_begin", game_begin, 0);
      video_on = 1'b0;
      @(negedge clk);
      clr_n = 1'b1;
   endtask

   always @(posedge clk) begin
      if (px_issue) begin
         #1;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_underflow: got pixel rgb=%h with no expectation queued", rgb);
         end else begin
            mon_p = exp_q.pop_front();
            if (rgb !== mon_p.rgb || rgb_valid !== mon_p.valid || hit !== mon_p.hit) begin
               errors++;
               $display("FAIL %s: got rgb=%h valid=%b hit=%b expected rgb=%h valid=%b hit=%b",
                        mon_p.name, rgb, rgb_valid, hit, mon_p.rgb, mon_p.valid, mon_p.hit);
            end else begin
               $display("ok   %s: rgb=%h valid=%b hit=%b", mon_p.name, rgb, rgb_valid, hit);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   initial begin
      rgb_in     = {CC, CB, CA};
      layer_mask = 3'b111;
      repeat (3) @(negedge clk);
      check("reset_state", state, 0);
      check("reset_rgb", rgb, 0);
      check("reset_valid", rgb_valid, 0);
      check("reset_hit", hit, 0);
      check("reset_scroll", scroll_x, 0);
      check("reset_game_begin", game_begin, 0);
      clr_n = 1'b1;

      // Layer 0 is splash-masked: background for all ten splash cycles.
      for (int i = 1; i <= 10; i++) begin
         pixel($sformatf("splash_px%0d", i), 1'b1, 3'b001, 3'b111, BG, 1'b0);
         check($sformatf("splash_state%0d", i), state, (i < 10) ? 0 : 1);
      end
      check("game_begin_after_splash", game_begin, 1);
      pixel("layer0_after_splash", 1'b1, 3'b001, 3'b111, CA, 1'b1);

      pixel("prio_all_on", 1'b1, 3'b111, 3'b111, CC, 1'b1);
      pixel("prio_mask_011", 1'b1, 3'b111, 3'b011, CB, 1'b1);
      pixel("prio_only_1", 1'b1, 3'b010, 3'b111, CB, 1'b1);
      pixel("prio_on101_mask110", 1'b1, 3'b101, 3'b110, CC, 1'b1);
      pixel("prio_none_on", 1'b1, 3'b000, 3'b111, BG, 1'b0);
      pixel("prio_all_masked", 1'b1, 3'b111, 3'b000, BG, 1'b0);
      pixel("blank_video_off", 1'b0, 3'b111, 3'b111, 12'h000, 1'b0);

      rgb_in = {12'h000, CB, CA};
`ifdef LAYER_KEY_EN
      pixel("key_top_transparent", 1'b1, 3'b110, 3'b111, CB, 1'b1);
`else
      pixel("key_ignored", 1'b1, 3'b110, 3'b111, 12'h000, 1'b1);
`endif
      rgb_in = {CC, CB, CA};

      // DIV=2, MAX=3: every second tick advances, wrapping 3 -> 0.
      for (int i = 1; i <= 10; i++) begin
         tick();
         check($sformatf("scroll_tick%0d", i), scroll_x, (i / 2) % 4);
      end

      skip = 1'b1;
      @(negedge clk);
      skip = 1'b0;
      check("skip_in_run_state", state, 1);
      check("skip_in_run_scroll", scroll_x, 1);

      pause = 1'b1;
      @(negedge clk);
      check("pause_state", state, 2);
      check("pause_game_begin", game_begin, 1);
      repeat (4) tick();
      check("pause_scroll_frozen", scroll_x, 1);
      skip = 1'b1;
      @(negedge clk);
      skip = 1'b0;
      check("skip_in_pause_state", state, 2);
      pause = 1'b0;
      @(negedge clk);
      check("unpause_state", state, 1);
      tick();
      check("resume_tick1", scroll_x, 1);
      tick();
      check("resume_tick2", scroll_x, 2);

      // Skip on the third edge after release, with an f_tick on that same edge.
      do_reset();
      pixel("rel_px1", 1'b1, 3'b001, 3'b111, BG, 1'b0);
      check("rel_state1", state, 0);
      pixel("rel_px2", 1'b1, 3'b001, 3'b111, BG, 1'b0);
      check("rel_state2", state, 0);
      skip   = 1'b1;
      f_tick = 1'b1;
      pixel("rel_px3_skip", 1'b1, 3'b001, 3'b111, BG, 1'b0);
      skip   = 1'b0;
      f_tick = 1'b0;
      check("skip_to_run_state", state, 1);
      check("skip_to_run_game_begin", game_begin, 1);
      pixel("rel_px4_run", 1'b1, 3'b001, 3'b111, CA, 1'b1);
      tick();
      check("ftick_on_run_edge_not_counted", scroll_x, 0);
      tick();
      check("scroll_after_two_ticks", scroll_x, 1);

      // Skip coincident with timer expiry: a single SPLASH->RUN transition.
      do_reset();
      for (int i = 1; i <= 10; i++) begin
         if (i == 10) begin
            skip   = 1'b1;
            f_tick = 1'b1;
         end
         pixel($sformatf("expiry_px%0d", i), 1'b1, 3'b001, 3'b111, BG, 1'b0);
         check($sformatf("expiry_state%0d", i), state, (i < 10) ? 0 : 1);
      end
      skip   = 1'b0;
      f_tick = 1'b0;
      @(negedge clk);
      check("expiry_single_transition", state, 1);
      check("expiry_ftick_not_counted", scroll_x, 0);
      tick();
      check("expiry_first_tick", scroll_x, 0);

      repeat (2) @(negedge clk);
      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL scoreboard_leftover: got %0d pending expected 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
